// File: rtl/fp_add_seq_if.sv
// fp_add_seq_if: request, ordered-operand and result bus between requester, fp_add_seq and the adder stage
interface fp_add_seq_if;
  logic        start;
  logic        sub;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] res_in;
  logic        ovf_in;
  logic [5:0]  cnt;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  modport master (
    output start, sub, op_a, op_b, res_in, ovf_in,
    input  cnt, a_out, b_out, busy, done, result, overflow
  );
  modport slave (
    input  start, sub, op_a, op_b, res_in, ovf_in,
    output cnt, a_out, b_out, busy, done, result, overflow
  );
endinterface

// File: rtl/fp_add_seq.sv
// fp_add_seq: sequences an FP add/sub through an external adder stage; FP_SEQ_ZERO_BYPASS_EN enables the zero-operand shortcut
module fp_add_seq #(
  parameter logic [5:0] LAST_CNT = 6'd58
) (
  input logic clk,
  input logic rst_n,
  fp_add_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [31:0] b_adj;
  logic swap;
  assign b_adj = {bus.op_b[31] ^ bus.sub, bus.op_b[30:0]};
  assign swap = (b_adj[30:23] > bus.op_a[30:23]) ||
                (b_adj[30:23] == bus.op_a[30:23] && b_adj[22:0] > bus.op_a[22:0]);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.cnt      <= 6'd0;
      bus.a_out    <= 32'd0;
      bus.b_out    <= 32'd0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= 32'd0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.a_out <= swap ? b_adj : bus.op_a;
            bus.b_out <= swap ? bus.op_a : b_adj;
            bus.cnt   <= 6'd0;
            bus.busy  <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
`ifdef FP_SEQ_ZERO_BYPASS_EN
          if (bus.b_out[30:0] == 31'd0) begin
            bus.result   <= bus.a_out;
            bus.overflow <= 1'b0;
            bus.done     <= 1'b1;
            state        <= DONE;
          end else if (bus.cnt == LAST_CNT) state <= DRAIN;
          else bus.cnt <= bus.cnt + 6'd1;
`else
          if (bus.cnt == LAST_CNT) state <= DRAIN;
          else bus.cnt <= bus.cnt + 6'd1;
`endif
        end
        DRAIN: begin
          bus.result   <= bus.res_in;
          bus.overflow <= bus.ovf_in;
          bus.done     <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          bus.cnt  <= 6'd0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_seq.sv
// tb_fp_add_seq: scoreboard bench for fp_add_seq ordering, latency, capture, start masking and reset abort
module tb_fp_add_seq;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  fp_add_seq_if bus();
  fp_add_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] r, input logic o, input bit repulse);
    exp_t e;
    logic [31:0] bb, prev;
    bit byp, bad_hold, bad_res, pulsed;
    int n;
    logic [5:0] mid;
    bb = {b[31] ^ s, b[30:0]};
    e.a = (bb[30:0] > a[30:0]) ? bb : a;
    e.b = (bb[30:0] > a[30:0]) ? a : bb;
`ifdef FP_SEQ_ZERO_BYPASS_EN
    byp = (e.b[30:0] == 31'd0);
`else
    byp = 1'b0;
`endif
    e.res = byp ? e.a : r;
    e.ovf = byp ? 1'b0 : o;
    e.lat = byp ? 2 : 61;
    sb.push_back(e);
    prev = bus.result;
    bus.op_a = a; bus.op_b = b; bus.sub = s; bus.res_in = r; bus.ovf_in = o; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1; bad_hold = 0; bad_res = 0; pulsed = 0; mid = 6'h3f;
    chk("a_out", bus.a_out, e.a);
    chk("b_out", bus.b_out, e.b);
    chk("busy", bus.busy, 1);
    while (!bus.done && n < 100) begin
      if (bus.a_out !== e.a || bus.b_out !== e.b) bad_hold = 1;
      if (bus.result !== prev) bad_res = 1;
      if (repulse && !pulsed && bus.cnt == 6'd10) begin
        pulsed = 1;
        bus.op_a = 32'hC1200000; bus.op_b = 32'h42C80000; bus.sub = ~s; bus.start = 1'b1;
      end else bus.start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (n == 30) mid = bus.cnt;
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    chk("done", bus.done, 1);
    chk("latency", n, e.lat);
    chk("result", bus.result, e.res);
    chk("overflow", bus.overflow, e.ovf);
    chk("hold_ab", {31'd0, bad_hold}, 0);
    chk("res_stable", {31'd0, bad_res}, 0);
    if (e.lat == 61) chk("cnt_mid", mid, 29);
    @(posedge clk); #1;
    chk("done_clr", bus.done, 0);
    chk("busy_clr", bus.busy, 0);
    chk("cnt_clr", bus.cnt, 0);
    chk("res_held", bus.result, e.res);
    if (repulse) begin
      bad_hold = 0;
      repeat (70) begin
        @(posedge clk); #1;
        if (bus.done) bad_hold = 1;
      end
      chk("single_done", {31'd0, bad_hold}, 0);
    end
  endtask
  task automatic run_abort();
    int n;
    bit seen;
    bus.op_a = 32'h40000000; bus.op_b = 32'h40000000; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (bus.cnt != 6'd20 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_cnt20", bus.cnt, 20);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_cnt", bus.cnt, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_done", bus.done, 0);
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1;
    end
    chk("abort_no_done", {31'd0, seen}, 0);
  endtask
  initial begin
    bus.start = 0; bus.sub = 0; bus.op_a = 0; bus.op_b = 0; bus.res_in = 0; bus.ovf_in = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", bus.cnt, 0);
    chk("rst_a", bus.a_out, 0);
    chk("rst_b", bus.b_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_ovf", bus.overflow, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h3F800000, 32'h3F800000, 0, 32'h40000000, 0, 0);
    run_op(32'h3F800000, 32'h40800000, 0, 32'h40A00000, 0, 0);
    run_op(32'h40400000, 32'h3F800000, 1, 32'h40000000, 0, 0);
    run_op(32'h3F800000, 32'h40400000, 1, 32'hC0000000, 0, 0);
    run_op(32'h3F800000, 32'h3FC00000, 0, 32'h40200000, 0, 0);
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 1, 0);
    run_op(32'h40A00000, 32'h00000000, 0, 32'h40A00000, 0, 0);
    run_op(32'h40000000, 32'h3F800000, 0, 32'h40400000, 0, 1);
    run_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_add_seq.md
FP_ADD_SEQ -- requirements
Module: fp_add_seq

Interface
REQ-001 The block SHALL have one parameter: LAST_CNT, 6'd58, final step value driven on cnt before the drain cycle.
REQ-002 The block SHALL have the following ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- sub  input  1  1 = compute op_a - op_b, 0 = op_a + op_b; sampled with start.
- op_a  input  32  IEEE-754 single operand A.
- op_b  input  32  IEEE-754 single operand B.
- res_in  input  32  result from the downstream adder stage.
- ovf_in  input  1  overflow from the downstream adder stage.
- cnt  output  6  step counter to the adder stage.
- a_out  output  32  larger-magnitude operand to the adder stage.
- b_out  output  32  smaller-magnitude operand to the adder stage, sign adjusted.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.
- result  output  32  captured sum, held until the next done.
- overflow  output  1  captured overflow flag, held with result.

Function
REQ-003 The block SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-004 In IDLE with start=1, at the next edge the block SHALL register a_out/b_out, set cnt=0, set busy=1 and enter RUN.
REQ-005 The block SHALL order the operands by magnitude: it swaps when exp(op_b) > exp(op_a), or when the exponents are equal and mant(op_b) > mant(op_a); otherwise it does not swap.
REQ-006 When sub=1, the block SHALL invert bit 31 of the original op_b before ordering, so the subtrahend may land on either a_out or b_out.
REQ-007 In RUN, cnt SHALL increment by 1 per cycle; at cnt==LAST_CNT the next state SHALL be DRAIN, with cnt held at LAST_CNT.
REQ-008 DRAIN SHALL last exactly one cycle, after which the block enters DONE.
REQ-009 On the edge entering DONE, the block SHALL set result<=res_in, overflow<=ovf_in and done=1.
REQ-010 In DONE, the block SHALL return to IDLE on the next edge with done=0, busy=0 and cnt=0.
REQ-011 Latency SHALL be LAST_CNT+3 cycles from the start-sampling edge to done high (61 at the default).
REQ-012 start SHALL be ignored in RUN, DRAIN and DONE, and a_out/b_out SHALL stay stable throughout the operation.
REQ-013 cnt SHALL never wrap; LAST_CNT SHALL be 33..62.
REQ-014 result and overflow SHALL change only on done.

Reset
REQ-015 With rst_n=0 at a clock edge, the block SHALL enter IDLE with cnt=0, a_out=0, b_out=0, busy=0, done=0, result=0 and overflow=0.
REQ-016 A reset mid-operation SHALL abort it immediately, with no done pulse and with result cleared.

Configuration
REQ-017 With FP_SEQ_ZERO_BYPASS_EN defined, if the ordered b_out has exponent and mantissa both 0, the block SHALL skip RUN/DRAIN and enter DONE on the next edge, with result=a_out, overflow=0 and latency 2.
REQ-018 Without FP_SEQ_ZERO_BYPASS_EN, all operands SHALL follow the full RUN path.

Verification
REQ-019 1.0+1.0: op_a=op_b=0x3F800000, sub=0, res_in modelled by the adder -> done 61 cycles after start, result=0x40000000, overflow=0.
REQ-020 Swap: op_a=0x3F800000, op_b=0x40800000 -> a_out=0x40800000, b_out=0x3F800000, both held until done.
REQ-021 Subtract: op_a=0x40400000, op_b=0x3F800000, sub=1 -> a_out=0x40400000, b_out=0xBF800000; result=0x40000000.
REQ-022 Zero bypass with the macro: op_a=0x40A00000, op_b=0 -> done 2 cycles after start, result=0x40A00000, cnt stays 0; without the macro, done comes at 61 cycles.
REQ-023 Reset at cnt=20 -> next cycle cnt=0, busy=0, result=0, and no done within 70 cycles.
REQ-024 start re-pulsed at cnt=10 with different operands -> ignored; a_out/b_out unchanged and a single done at cycle 61.
